// File: rtl/quaddectest_cpu_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-atom packets with flush, drain and overflow handling.
// The output slot is a register separate from the accumulator, so one packet can wait while the next one fills.
module quaddectest_cpu_oci_dct_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        atom_valid,
  input  logic [1:0]  atom,
  output logic        atom_ready,
  input  logic        flush,
  input  logic        test_ending,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic        test_has_ended,
  output logic        overflow
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ENDED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] acc_q, acc_d;
  logic [3:0]  accCnt_q, accCnt_d;
  logic        flushPend_q, flushPend_d;
  logic [29:0] dctBuffer_q, dctBuffer_d;
  logic [3:0]  dctCount_q, dctCount_d;
  logic        pktValid_q, pktValid_d;
  logic        overflow_q, overflow_d;

  logic slotFree;
  logic accept;
  logic transfer;

  always_comb begin
    slotFree   = !pktValid_q || pkt_ready;
    atom_ready = (state_q == RUN) && ((accCnt_q != 4'd15) || slotFree);
    accept     = atom_valid && atom_ready;
    transfer   = slotFree && ((accCnt_q == 4'd15) || (flushPend_q && (accCnt_q != 4'd0)));
  end

  always_comb begin
    acc_d       = acc_q;
    accCnt_d    = accCnt_q;
    flushPend_d = flushPend_q;
    dctBuffer_d = dctBuffer_q;
    dctCount_d  = dctCount_q;
    pktValid_d  = pktValid_q;
    overflow_d  = overflow_q;
    state_d     = state_q;

    // A transfer empties the accumulator; an atom accepted on the same edge starts the next packet.
    if (transfer) begin
      dctBuffer_d = acc_q;
      dctCount_d  = accCnt_q;
      pktValid_d  = 1'b1;
      acc_d       = accept ? {28'b0, atom} : 30'b0;
      accCnt_d    = accept ? 4'd1 : 4'd0;
    end else begin
      if (pktValid_q && pkt_ready) begin
        pktValid_d = 1'b0;
      end
      if (accept) begin
        acc_d    = {acc_q[27:0], atom};
        accCnt_d = accCnt_q + 4'd1;
      end
    end

    if (transfer) begin
      flushPend_d = 1'b0;
    end else if (flushPend_q && (accCnt_q == 4'd0)) begin
      flushPend_d = 1'b0;
    end
    if ((state_q == RUN) && flush && !transfer) begin
      flushPend_d = 1'b1;
    end
    // Entering drain always re-arms the flush so an atom taken on the entry edge still leaves.
    if ((state_q == RUN) && test_ending) begin
      flushPend_d = 1'b1;
    end

    if ((state_q == RUN) && atom_valid && !atom_ready) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (test_ending) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((accCnt_q == 4'd0) && slotFree) begin
          state_d = ENDED;
        end
      end
      ENDED: begin
        state_d = ENDED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= RUN;
      acc_q       <= 30'b0;
      accCnt_q    <= 4'd0;
      flushPend_q <= 1'b0;
      dctBuffer_q <= 30'b0;
      dctCount_q  <= 4'd0;
      pktValid_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      accCnt_q    <= accCnt_d;
      flushPend_q <= flushPend_d;
      dctBuffer_q <= dctBuffer_d;
      dctCount_q  <= dctCount_d;
      pktValid_q  <= pktValid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign dct_buffer     = dctBuffer_q;
  assign dct_count      = dctCount_q;
  assign pkt_valid      = pktValid_q;
  assign overflow       = overflow_q;
  assign test_has_ended = (state_q == ENDED);

endmodule

// File: tb/tb_quaddectest_cpu_oci_dct_packer.sv
// Scoreboard bench for the DCT atom packer: a queue-based model predicts packets, a monitor checks them on handshake.
module tb_quaddectest_cpu_oci_dct_packer;

  logic        clk;
  logic        reset_n;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        atom_ready;
  logic        flush;
  logic        test_ending;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        test_has_ended;
  logic        overflow;

  quaddectest_cpu_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .atom_valid     (atom_valid),
    .atom           (atom),
    .atom_ready     (atom_ready),
    .flush          (flush),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .pkt_valid      (pkt_valid),
    .pkt_ready      (pkt_ready),
    .test_has_ended (test_has_ended),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] data;
    logic [3:0]  cnt;
  } pkt_t;

  // Model state: atoms waiting in arrival order, the held packet flag, and a 0/1/2 phase (run/drain/ended).
  pkt_t expQ[$];
  int   accQ[$];
  bit   mValid;
  bit   mFlush;
  bit   mOverflow;
  bit   mReady;
  int   mPhase;
  int   pktSeen;
  int   checkCount;
  int   errorCount;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [29:0] packAcc();
    logic [29:0] d;
    d = '0;
    foreach (accQ[i]) d = d * 30'd4 + 30'(accQ[i]);
    return d;
  endfunction

  task automatic modelStep();
    int   n;
    bit   slotFree;
    bit   take;
    bit   xfer;
    bit   newFlush;
    pkt_t p;
    if (!reset_n) begin
      accQ.delete();
      expQ.delete();
      mValid    = 0;
      mFlush    = 0;
      mOverflow = 0;
      mPhase    = 0;
      return;
    end
    n        = accQ.size();
    slotFree = !mValid || pkt_ready;
    take     = atom_valid && mReady;
    xfer     = slotFree && (n == 15 || (mFlush && n > 0));
    if (mPhase == 0 && atom_valid && !mReady) mOverflow = 1;
    newFlush = mFlush;
    if (xfer || n == 0) newFlush = 0;
    if (mPhase == 0 && flush && !xfer) newFlush = 1;
    if (mPhase == 0 && test_ending) newFlush = 1;
    if (xfer) begin
      p.data = packAcc();
      p.cnt  = 4'(n);
      expQ.push_back(p);
      accQ.delete();
      mValid = 1;
    end else if (mValid && pkt_ready) begin
      mValid = 0;
    end
    if (take) accQ.push_back(int'(atom));
    if (mPhase == 0 && test_ending) mPhase = 1;
    else if (mPhase == 1 && n == 0 && slotFree) mPhase = 2;
    mFlush = newFlush;
  endtask

  // One clock cycle: drive inputs, compare the visible state with the model, advance both.
  task automatic applyStimulus(input bit av, input logic [1:0] a, input bit fl, input bit te,
                               input bit pr, input bit rn);
    atom_valid  = av;
    atom        = a;
    flush       = fl;
    test_ending = te;
    pkt_ready   = pr;
    reset_n     = rn;
    #1;
    mReady = (mPhase == 0) && (accQ.size() < 15 || !mValid || pr);
    checkOutput("atom_ready", 32'(atom_ready), 32'(mReady));
    checkOutput("pkt_valid", 32'(pkt_valid), 32'(mValid));
    checkOutput("overflow", 32'(overflow), 32'(mOverflow));
    checkOutput("test_has_ended", 32'(test_has_ended), 32'(mPhase == 2));
    modelStep();
    @(posedge clk);
    #2;
  endtask

  // Monitor: the front of expQ is the packet the DUT should be holding; it retires on handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && pkt_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkCount++;
          errorCount++;
          $display("[TB] FAIL pkt_unexpected actual=count %0d data %0h expected=no packet", dct_count, dct_buffer);
        end else begin
          checkOutput("pkt_buffer", 32'(dct_buffer), 32'(expQ[0].data));
          checkOutput("pkt_count", 32'(dct_count), 32'(expQ[0].cnt));
          if (pkt_ready === 1'b1) begin
            void'(expQ.pop_front());
            pktSeen++;
          end
        end
      end
    end
  end

  initial begin
    int seenBefore;
    checkCount = 0;
    errorCount = 0;
    pktSeen    = 0;
    mValid     = 0;
    mFlush     = 0;
    mOverflow  = 0;
    mPhase     = 0;
    atom_valid  = 0;
    atom        = 2'd0;
    flush       = 0;
    test_ending = 0;
    pkt_ready   = 1;
    reset_n     = 0;
    repeat (2) @(posedge clk);
    #2;
    modelStep();
    #1;
    checkOutput("reset_buffer", 32'(dct_buffer), 32'd0);
    checkOutput("reset_count", 32'(dct_count), 32'd0);
    checkOutput("reset_pkt_valid", 32'(pkt_valid), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_ended", 32'(test_has_ended), 32'd0);
    checkOutput("reset_atom_ready", 32'(atom_ready), 32'd1);

    $display("[TB] full packet 0,1,2,3,...");
    for (int i = 0; i < 15; i++) applyStimulus(1, 2'(i % 4), 0, 0, 1, 1);
    applyStimulus(0, 2'd0, 0, 0, 1, 1);
    checkOutput("full_valid", 32'(pkt_valid), 32'd1);
    checkOutput("full_count", 32'(dct_count), 32'd15);
    checkOutput("full_buffer", 32'(dct_buffer), 32'h06C6C6C6);
    applyStimulus(0, 2'd0, 0, 0, 1, 1);

    $display("[TB] flush of three atoms");
    for (int i = 0; i < 3; i++) applyStimulus(1, 2'd3, 0, 0, 1, 1);
    applyStimulus(0, 2'd0, 1, 0, 1, 1);
    applyStimulus(0, 2'd0, 0, 0, 1, 1);
    checkOutput("flush_valid", 32'(pkt_valid), 32'd1);
    checkOutput("flush_count", 32'(dct_count), 32'd3);
    checkOutput("flush_buffer", 32'(dct_buffer), 32'h3F);
    applyStimulus(0, 2'd0, 0, 0, 1, 1);
    applyStimulus(0, 2'd0, 1, 0, 1, 1);
    repeat (3) applyStimulus(0, 2'd0, 0, 0, 1, 1);
    checkOutput("empty_flush_valid", 32'(pkt_valid), 32'd0);

    $display("[TB] backpressure with 31 atoms");
    seenBefore = pktSeen;
    for (int i = 0; i < 31; i++) applyStimulus(1, 2'($urandom % 4), 0, 0, 0, 1);
    checkOutput("bp_overflow", 32'(overflow), 32'd1);
    checkOutput("bp_held_count", 32'(dct_count), 32'd15);
    repeat (4) applyStimulus(0, 2'd0, 0, 0, 1, 1);
    checkOutput("bp_packets", 32'(pktSeen - seenBefore), 32'd2);

    $display("[TB] drain");
    for (int i = 0; i < 5; i++) applyStimulus(1, 2'($urandom % 4), 0, 0, 1, 1);
    applyStimulus(0, 2'd0, 0, 1, 1, 1);
    applyStimulus(0, 2'd0, 0, 1, 1, 1);
    checkOutput("drain_count", 32'(dct_count), 32'd5);
    checkOutput("drain_not_ended", 32'(test_has_ended), 32'd0);
    applyStimulus(0, 2'd0, 0, 1, 1, 1);
    checkOutput("drain_ended", 32'(test_has_ended), 32'd1);
    repeat (3) applyStimulus(1, 2'($urandom % 4), 1, 0, 1, 1);

    $display("[TB] reset during drain");
    applyStimulus(0, 2'd0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 2'($urandom % 4), 0, 0, 0, 1);
    applyStimulus(0, 2'd0, 0, 1, 0, 1);
    applyStimulus(0, 2'd0, 0, 1, 0, 1);
    checkOutput("rd_held_valid", 32'(pkt_valid), 32'd1);
    applyStimulus(0, 2'd0, 0, 0, 0, 0);
    checkOutput("rd_valid", 32'(pkt_valid), 32'd0);
    checkOutput("rd_buffer", 32'(dct_buffer), 32'd0);
    checkOutput("rd_count", 32'(dct_count), 32'd0);
    checkOutput("rd_ended", 32'(test_has_ended), 32'd0);
    checkOutput("rd_atom_ready", 32'(atom_ready), 32'd1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 4) != 0, 2'($urandom % 4), ($urandom % 16) == 0,
                    ($urandom % 400) == 0, ($urandom % 3) != 0, ($urandom % 300) != 0);
    end
    repeat (40) applyStimulus(0, 2'd0, 0, 0, 1, 1);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
